inst_issue_seq: RTL
===================

Name: inst_issue_seq

Overview:
- Instruction sequencer that sits directly upstream of the miniature processor's command interface (cmd/read1/read2/write/data, done).
- Holds a small program memory loaded over a write port, then, on start, issues one instruction at a time, waiting for the processor's done before issuing the next.
- Replaces the hand-coded instruction chain in the test top with a synthesizable, reusable front end.

Parameters:
- DEPTH, 32, number of program memory entries.
- ADDR_W, 5, program counter / memory address width; DEPTH <= 2**ADDR_W.
- TIMEOUT, 64, cycles allowed between issue and done (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin executing the program from entry 0; sampled at posedge.
- prog_we  in  1  program memory write enable.
- prog_addr  in  ADDR_W  program memory write address.
- prog_wdata  in  34  instruction word {cmd[33:31], read1[30:26], read2[25:21], write[20:16], data[15:0]}.
- prog_len  in  ADDR_W+1  number of valid instructions; sampled on accepted start.
- done  in  1  processor completion; high for at least one cycle per instruction.
- cmd  out  3  opcode to processor.
- read1  out  5  source register 1.
- read2  out  5  source register 2.
- write  out  5  destination register.
- data  out  16  signed immediate.
- issue  out  1  one-cycle pulse: new instruction presented on the field outputs.
- busy  out  1  high in ISSUE and WAIT.
- finished  out  1  high in HALT.
- pc  out  ADDR_W  index of the current/last issued instruction.
- err  out  1  timeout flag (see Optional Feature).

Behaviour:
- Reset: state=IDLE; cmd, read1, read2, write, data, pc, issue, busy, finished, err all 0; latched length 0. Memory contents are not cleared.
- States:
  - IDLE: on start, latch prog_len and set pc=0. Go to ISSUE if the length is nonzero, else go to HALT.
  - ISSUE (1 cycle): drive field outputs from mem[pc], assert issue for exactly this cycle, then go to WAIT.
  - WAIT: on done=1, if pc+1 == latched length go to HALT, else pc<=pc+1 and go to ISSUE.
  - HALT: finished=1. On start, restart as from IDLE, re-latching prog_len.
- Latency: start to first issue is 1 cycle. Done sampled to next issue is 1 cycle.
- Field outputs hold the last issued values through WAIT and HALT; they change only in ISSUE.
- done is honoured only in WAIT; done in IDLE, ISSUE or HALT is ignored. A done held high across ISSUE counts only once it is sampled in WAIT.
- start in ISSUE or WAIT is ignored.
- prog_we is accepted only in IDLE or HALT; writes while busy are dropped. A write to an address >= DEPTH is dropped.
- A prog_len larger than DEPTH is clamped to DEPTH. A length of 0 goes straight to HALT with no issue.
- pc never wraps: the last entry (DEPTH-1) halts after its done.
- Asynchronous reset mid-operation aborts immediately to IDLE with all outputs reset. The instruction in flight is abandoned.

Optional Feature:
- Macro ISSUE_TIMEOUT_EN.
- Defined: a cycle counter clears on each issue and counts while in WAIT. When it reaches TIMEOUT without done, go to HALT with err=1 and finished=1. err clears on the next accepted start or on reset.
- Undefined: WAIT waits indefinitely, no counter is built, and err is tied 0.

Test Plan:
- Load mem[0]={000,0,0,1,17}, mem[1]={011,1,0,2,-9}, len=2; start; ack each issue with done 3 cycles later -> issue pulses twice; the first presents cmd=000 write=1 data=17, the second cmd=011 read1=1 write=2 data=0xFFF7; then finished=1 and pc=1.
- Load the 9-instruction program, ending with cmd=001 read1=6; run with done acks -> exactly 9 issue pulses in order, finished after the 9th done, fields hold cmd=001 read1=6.
- prog_len=0, start -> finished=1 next cycle, no issue pulse, fields remain 0.
- While in WAIT at pc=1: pulse start, write mem[1] with new data, pulse done while in ISSUE -> all ignored; original mem[1] fields stay stable; only done sampled in WAIT advances pc.
- Deassert rst_n asynchronously while in WAIT at pc=4 -> outputs 0 and state IDLE without a clock edge; a later start re-runs from pc=0.
- With ISSUE_TIMEOUT_EN and TIMEOUT=8: issue but never assert done -> err=1 and finished=1 after 8 WAIT cycles; a following start clears err.

Source files
------------

// File: rtl/inst_issue_seq_if.sv
// Command bus between the instruction sequencer and the miniature processor.
// The sequencer (master) drives the instruction fields and the issue strobe;
// the processor (slave) answers with done once the instruction has completed.
interface inst_issue_seq_if;
    logic [2:0]  cmd;
    logic [4:0]  read1;
    logic [4:0]  read2;
    logic [4:0]  write;
    logic [15:0] data;
    logic        issue;
    logic        done;

    modport master (
        output cmd, read1, read2, write, data, issue,
        input  done
    );

    modport slave (
        input  cmd, read1, read2, write, data, issue,
        output done
    );
endinterface

// File: rtl/inst_issue_seq.sv
// Instruction issue sequencer: holds a small program memory loaded while idle,
// then issues one instruction at a time, waiting for the processor's done
// before presenting the next one.
// Optional feature macro: ISSUE_TIMEOUT_EN -- when defined, a WAIT that lasts
// TIMEOUT cycles without done aborts to HALT with err raised.
module inst_issue_seq #(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [33:0]       prog_wdata,
    input  logic [ADDR_W:0]   prog_len,
    inst_issue_seq_if.master  proc,
    output logic              busy,
    output logic              finished,
    output logic [ADDR_W-1:0] pc,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              issue_q, issue_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    // Set by the first issue after reset; until then the field outputs read 0
    // even though the read register itself has no reset.
    logic              valid_q, valid_d;

    logic [33:0]       mem [DEPTH];
    logic [33:0]       rd_word_q;
    logic [33:0]       fields;

    logic              idle_like;
    logic              we_ok;
    logic [ADDR_W:0]   len_clamped;

    assign idle_like   = (state_q == S_IDLE) || (state_q == S_HALT);
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    // Address check is done one bit wider so it stays meaningful when DEPTH
    // fills the whole address space.
    assign we_ok       = prog_we && idle_like && ({1'b0, prog_addr} < DEPTH_L);

`ifdef ISSUE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
`endif

    // Next-state, program counter, length latch and registered status outputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        valid_d = valid_q;
`ifdef ISSUE_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    len_d = len_clamped;
                    pc_d  = '0;
`ifdef ISSUE_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    state_d = (len_clamped == '0) ? S_HALT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (proc.done) begin
                    if (({1'b0, pc_q} + ONE_L) == len_q) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_ISSUE;
                    end
`ifdef ISSUE_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering ISSUE is the single point where a new instruction is fetched.
        if (state_d == S_ISSUE) begin
            valid_d = 1'b1;
`ifdef ISSUE_TIMEOUT_EN
            tmo_d   = '0;
`endif
        end

        issue_d = (state_d == S_ISSUE);
        busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT);
        fin_d   = (state_d == S_HALT);
    end

    // Control and status flops; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            valid_q <= valid_d;
        end
    end

`ifdef ISSUE_TIMEOUT_EN
    // WAIT watchdog counter and its sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Without the watchdog err can never be raised; TIMEOUT has no effect.
    assign err = (TIMEOUT < 0);
`endif

    // Program memory: write port while idle, registered read enabled on fetch.
    always_ff @(posedge clk) begin
        if (we_ok) begin
            mem[prog_addr] <= prog_wdata;
        end
        if (state_d == S_ISSUE) begin
            rd_word_q <= mem[pc_d];
        end
    end

    assign fields     = valid_q ? rd_word_q : '0;
    assign proc.cmd   = fields[33:31];
    assign proc.read1 = fields[30:26];
    assign proc.read2 = fields[25:21];
    assign proc.write = fields[20:16];
    assign proc.data  = fields[15:0];
    assign proc.issue = issue_q;

    assign busy     = busy_q;
    assign finished = fin_q;
    assign pc       = pc_q;

endmodule
